// File: rtl/hdc_csr_pkg.sv
// Shared CSR map, INPUT/STATUS field layout and sequencer state encoding
// for the SBD-HDC CSR sequencer.
package hdc_csr_pkg;

    localparam int unsigned CSR_CTRL   = 0;
    localparam int unsigned CSR_INPUT  = 1;
    localparam int unsigned CSR_STATUS = 2;

    localparam int unsigned IN_VALID_BIT  = 0;
    localparam int unsigned IN_VALUE_LSB  = 1;
    localparam int unsigned IN_SHIFT_LSB  = 7;
    localparam int unsigned IN_DONE_BIT   = 13;
    localparam int unsigned IN_WORD_WIDTH = 14;
    localparam int unsigned FIELD_WIDTH   = 6;

    localparam int unsigned ST_IN_READY_BIT  = 1;
    localparam int unsigned ST_OUT_VALID_BIT = 2;
    localparam int unsigned ST_CLASS_LSB     = 3;
    localparam int unsigned CLASS_WIDTH      = 5;

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_WAIT_SMP,
        S_POLL_RDY,
        S_WR_IN,
        S_CLR_IN,
        S_DONE_WR,
        S_POLL_OUT,
        S_CLR_DONE,
        S_RESULT
    } seq_state_e;

    // Packs one CSR_INPUT word; every bit above the done flag stays zero.
    function automatic logic [IN_WORD_WIDTH-1:0] input_word(
        input logic                   valid,
        input logic [FIELD_WIDTH-1:0] value,
        input logic [FIELD_WIDTH-1:0] shift,
        input logic                   done
    );
        logic [IN_WORD_WIDTH-1:0] w;
        w                              = '0;
        w[IN_VALID_BIT]                = valid;
        w[IN_VALUE_LSB +: FIELD_WIDTH] = value;
        w[IN_SHIFT_LSB +: FIELD_WIDTH] = shift;
        w[IN_DONE_BIT]                 = done;
        return w;
    endfunction

endpackage

// File: rtl/hdc_poll_timer.sv
// Saturating count of failed STATUS polls; flags expiry on the read that
// brings the count to LIMIT so the caller can abort on that same handshake.
module hdc_poll_timer #(
    parameter int unsigned LIMIT = 1024
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic inc_i,
    output logic expired_o
);

    localparam int unsigned CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count <= '0;
        end else if (clear_i) begin
            count <= '0;
        end else if (inc_i && (count < CW'(LIMIT))) begin
            count <= count + 1'b1;
        end
    end

    assign expired_o = (count == CW'(LIMIT)) ||
                       (inc_i && (count == CW'(LIMIT - 1)));

endmodule

// File: rtl/hdc_csr_sequencer.sv
// Autonomous CSR master: starts an HDC run, streams samples into CSR_INPUT
// under STATUS.in_ready flow control, then polls for the class result.
module hdc_csr_sequencer
    import hdc_csr_pkg::*;
#(
    parameter int unsigned CSR_WIDTH      = 32,
    parameter int unsigned CSR_ADDR_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      start_i,
    input  logic [5:0]                cfg_shift_i,
    input  logic                      smp_valid_i,
    output logic                      smp_ready_o,
    input  logic [5:0]                smp_value_i,
    input  logic                      smp_last_i,
    output logic                      res_valid_o,
    input  logic                      res_ready_i,
    output logic [4:0]                res_class_o,
    output logic                      res_timeout_o,
    output logic                      busy_o,
    output logic [CSR_ADDR_WIDTH-1:0] csr_addr_o,
    output logic [CSR_WIDTH-1:0]      csr_wr_data_o,
    output logic                      csr_wr_en_o,
    output logic                      csr_req_valid_o,
    input  logic                      csr_req_ready_i,
    input  logic [CSR_WIDTH-1:0]      csr_rd_data_i,
    input  logic                      csr_rsp_valid_i,
    output logic                      csr_rsp_ready_o
);

    typedef struct packed {
        logic                      valid;
        logic                      wr;
        logic [CSR_ADDR_WIDTH-1:0] addr;
        logic [CSR_WIDTH-1:0]      data;
    } csr_req_t;

    function automatic csr_req_t csr_write(input int unsigned a,
                                           input logic [IN_WORD_WIDTH-1:0] w);
        csr_req_t r;
        r.valid = 1'b1;
        r.wr    = 1'b1;
        r.addr  = CSR_ADDR_WIDTH'(a);
        r.data  = CSR_WIDTH'(w);
        return r;
    endfunction

    function automatic csr_req_t csr_read(input int unsigned a);
        csr_req_t r;
        r       = '0;
        r.valid = 1'b1;
        r.addr  = CSR_ADDR_WIDTH'(a);
        return r;
    endfunction

    seq_state_e       state;
    csr_req_t         req_q;
    logic [5:0]       shift_q;
    logic [5:0]       value_q;
    logic             last_q;
    logic [4:0]       class_q;
    logic             timeout_q;
    logic             smp_ready_q;
    logic             res_valid_q;
    logic             busy_q;

    logic             hs;
    logic             in_ready;
    logic             out_valid;
    logic             timer_clear;
    logic             timer_inc;
    logic             poll_expired;

    assign hs        = req_q.valid && csr_req_ready_i;
    assign in_ready  = csr_rd_data_i[ST_IN_READY_BIT];
    assign out_valid = csr_rd_data_i[ST_OUT_VALID_BIT];

    // The counter restarts on every entry into a poll phase and counts only
    // completed reads that came back negative.
    assign timer_clear = (state == S_IDLE     && start_i)     ||
                         (state == S_WAIT_SMP && smp_valid_i) ||
                         (state == S_DONE_WR  && hs);
    assign timer_inc   = hs && ((state == S_POLL_RDY && !in_ready) ||
                                (state == S_POLL_OUT && !out_valid));

    hdc_poll_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_poll_timer (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear_i   (timer_clear),
        .inc_i     (timer_inc),
        .expired_o (poll_expired)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= S_IDLE;
            req_q       <= '0;
            shift_q     <= '0;
            value_q     <= '0;
            last_q      <= 1'b0;
            class_q     <= '0;
            timeout_q   <= 1'b0;
            smp_ready_q <= 1'b0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        shift_q   <= cfg_shift_i;
                        class_q   <= '0;
                        timeout_q <= 1'b0;
                        busy_q    <= 1'b1;
                        req_q     <= csr_write(CSR_CTRL, IN_WORD_WIDTH'(1));
                        state     <= S_START;
                    end
                end
                S_START: begin
                    if (hs) begin
                        req_q       <= '0;
                        smp_ready_q <= 1'b1;
                        state       <= S_WAIT_SMP;
                    end
                end
                S_WAIT_SMP: begin
                    if (smp_valid_i) begin
                        value_q     <= smp_value_i;
                        last_q      <= smp_last_i;
                        smp_ready_q <= 1'b0;
                        req_q       <= csr_read(CSR_STATUS);
                        state       <= S_POLL_RDY;
                    end
                end
                S_POLL_RDY: begin
                    if (hs) begin
                        if (in_ready) begin
                            req_q <= csr_write(CSR_INPUT,
                                               input_word(1'b1, value_q, shift_q, 1'b0));
                            state <= S_WR_IN;
                        end else if (poll_expired) begin
                            timeout_q <= 1'b1;
                            class_q   <= '0;
                            req_q     <= csr_write(CSR_INPUT, '0);
                            state     <= S_CLR_DONE;
                        end
                    end
                end
                S_WR_IN: begin
                    if (hs) begin
                        req_q <= csr_write(CSR_INPUT,
                                           input_word(1'b0, '0, shift_q, 1'b0));
                        state <= S_CLR_IN;
                    end
                end
                S_CLR_IN: begin
                    if (hs) begin
                        if (last_q) begin
                            req_q <= csr_write(CSR_INPUT,
                                               input_word(1'b0, '0, shift_q, 1'b1));
                            state <= S_DONE_WR;
                        end else begin
                            req_q       <= '0;
                            smp_ready_q <= 1'b1;
                            state       <= S_WAIT_SMP;
                        end
                    end
                end
                S_DONE_WR: begin
                    if (hs) begin
                        req_q <= csr_read(CSR_STATUS);
                        state <= S_POLL_OUT;
                    end
                end
                S_POLL_OUT: begin
                    if (hs) begin
                        if (out_valid) begin
                            class_q <= csr_rd_data_i[ST_CLASS_LSB +: CLASS_WIDTH];
                            req_q   <= csr_write(CSR_INPUT, '0);
                            state   <= S_CLR_DONE;
                        end else if (poll_expired) begin
                            timeout_q <= 1'b1;
                            class_q   <= '0;
                            req_q     <= csr_write(CSR_INPUT, '0);
                            state     <= S_CLR_DONE;
                        end
                    end
                end
                S_CLR_DONE: begin
                    if (hs) begin
                        req_q       <= '0;
                        res_valid_q <= 1'b1;
                        state       <= S_RESULT;
                    end
                end
                S_RESULT: begin
                    // start_i is not looked at here, so a start coinciding
                    // with the accept is dropped rather than queued.
                    if (res_ready_i) begin
                        res_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: begin
                    req_q       <= '0;
                    smp_ready_q <= 1'b0;
                    res_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

    assign csr_req_valid_o = req_q.valid;
    assign csr_wr_en_o     = req_q.wr;
    assign csr_addr_o      = req_q.addr;
    assign csr_wr_data_o   = req_q.data;
    assign csr_rsp_ready_o = 1'b1;
    assign smp_ready_o     = smp_ready_q;
    assign res_valid_o     = res_valid_q;
    assign res_class_o     = class_q;
    assign res_timeout_o   = timeout_q;
    assign busy_o          = busy_q;

    // Responses are defined to arrive with the handshake, and only the
    // STATUS fields above matter, so the rest of the read word is dropped.
    logic unused_rsp;
    assign unused_rsp = ^{csr_rsp_valid_i, csr_rd_data_i};

endmodule

// File: tb/tb_hdc_csr_sequencer.sv
// Directed bench for hdc_csr_sequencer: a default-timeout instance for the
// streaming/stall/reset/result cases and an 8-poll-timeout instance.
module tb_hdc_csr_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, start_t;
    logic [5:0]  cfg_shift;
    logic        smp_valid;
    logic [5:0]  smp_value;
    logic        smp_last;
    logic        res_ready;
    logic        csr_req_ready;
    logic [31:0] status_val;

    logic        smp_ready, res_valid, res_timeout, busy;
    logic [4:0]  res_class;
    logic [31:0] csr_addr, csr_wr_data;
    logic        csr_wr_en, csr_req_valid, csr_rsp_ready, rsp_valid;

    logic        smp_ready_t, res_valid_t, res_timeout_t, busy_t;
    logic [4:0]  res_class_t;
    logic [31:0] csr_addr_t, csr_wr_data_t;
    logic        csr_wr_en_t, csr_req_valid_t, csr_rsp_ready_t, rsp_valid_t;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];
    logic [31:0] log_addr_t[$];
    logic [31:0] log_data_t[$];
    int rd_count  = 0;
    int wr1_count = 0;
    int post_done_reads = 0;

    always #5 clk = ~clk;

    assign rsp_valid   = csr_req_valid   && csr_req_ready && !csr_wr_en;
    assign rsp_valid_t = csr_req_valid_t && csr_req_ready && !csr_wr_en_t;

    hdc_csr_sequencer dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .cfg_shift_i(cfg_shift),
        .smp_valid_i(smp_valid), .smp_ready_o(smp_ready), .smp_value_i(smp_value),
        .smp_last_i(smp_last), .res_valid_o(res_valid), .res_ready_i(res_ready),
        .res_class_o(res_class), .res_timeout_o(res_timeout), .busy_o(busy),
        .csr_addr_o(csr_addr), .csr_wr_data_o(csr_wr_data), .csr_wr_en_o(csr_wr_en),
        .csr_req_valid_o(csr_req_valid), .csr_req_ready_i(csr_req_ready),
        .csr_rd_data_i(status_val), .csr_rsp_valid_i(rsp_valid),
        .csr_rsp_ready_o(csr_rsp_ready)
    );

    hdc_csr_sequencer #(.TIMEOUT_CYCLES(8)) dut_t (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_t), .cfg_shift_i(cfg_shift),
        .smp_valid_i(smp_valid), .smp_ready_o(smp_ready_t), .smp_value_i(smp_value),
        .smp_last_i(smp_last), .res_valid_o(res_valid_t), .res_ready_i(res_ready),
        .res_class_o(res_class_t), .res_timeout_o(res_timeout_t), .busy_o(busy_t),
        .csr_addr_o(csr_addr_t), .csr_wr_data_o(csr_wr_data_t), .csr_wr_en_o(csr_wr_en_t),
        .csr_req_valid_o(csr_req_valid_t), .csr_req_ready_i(csr_req_ready),
        .csr_rd_data_i(status_val), .csr_rsp_valid_i(rsp_valid_t),
        .csr_rsp_ready_o(csr_rsp_ready_t)
    );

    // Bus monitors: record completed transactions of each instance.
    always @(posedge clk) begin
        if (csr_req_valid && csr_req_ready) begin
            if (csr_wr_en) begin
                log_addr.push_back(csr_addr);
                log_data.push_back(csr_wr_data);
                if (csr_addr == 32'd1) wr1_count++;
            end else begin
                rd_count++;
            end
        end
        if (csr_req_valid_t && csr_req_ready) begin
            if (csr_wr_en_t) begin
                log_addr_t.push_back(csr_addr_t);
                log_data_t.push_back(csr_wr_data_t);
            end else if (log_data_t.size() >= 4) begin
                post_done_reads++;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input bit use_t);
        @(negedge clk);
        if (use_t) start_t = 1'b1; else start = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        start_t = 1'b0;
    endtask

    task automatic send_sample(input logic [5:0] v, input logic last, input bit use_t);
        int guard;
        @(negedge clk);
        smp_valid = 1'b1;
        smp_value = v;
        smp_last  = last;
        guard = 0;
        while (!(use_t ? smp_ready_t : smp_ready) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("smp_accept", 32'(use_t ? smp_ready_t : smp_ready), 32'd1);
        @(negedge clk);
        smp_valid = 1'b0;
        smp_last  = 1'b0;
    endtask

    task automatic wait_result(input bit use_t);
        int guard;
        guard = 0;
        while (!(use_t ? res_valid_t : res_valid) && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        check("res_valid_wait", 32'(use_t ? res_valid_t : res_valid), 32'd1);
    endtask

    task automatic accept_result();
        @(negedge clk);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic clear_logs();
        log_addr.delete();
        log_data.delete();
        log_addr_t.delete();
        log_data_t.delete();
        rd_count        = 0;
        wr1_count       = 0;
        post_done_reads = 0;
    endtask

    // shift=3, samples 5/17/63, STATUS 0x02 then 0x5C -> class 11.
    task automatic run_case1(input string pfx);
        logic [31:0] exp_a[9];
        logic [31:0] exp_d[9];
        int guard;
        exp_a = '{32'd0, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1};
        exp_d = '{32'h1, 32'h18B, 32'h180, 32'h1A3, 32'h180, 32'h1FF, 32'h180,
                  32'h2180, 32'h0};
        clear_logs();
        status_val    = 32'h02;
        csr_req_ready = 1'b1;
        cfg_shift     = 6'd3;
        pulse_start(1'b0);
        send_sample(6'd5,  1'b0, 1'b0);
        send_sample(6'd17, 1'b0, 1'b0);
        send_sample(6'd63, 1'b1, 1'b0);
        guard = 0;
        while (log_data.size() < 8 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check({pfx, "_done_written"}, 32'(log_data.size()), 32'd8);
        repeat (3) @(negedge clk);
        check({pfx, "_polling_busy"}, {30'd0, busy, res_valid}, 32'b10);
        status_val = 32'h5C;
        wait_result(1'b0);
        check({pfx, "_class"},   32'(res_class),   32'd11);
        check({pfx, "_timeout"}, 32'(res_timeout), 32'd0);
        check({pfx, "_wr_count"}, 32'(log_data.size()), 32'd9);
        for (int i = 0; i < 9 && i < log_data.size(); i++) begin
            check($sformatf("%s_wr%0d_addr", pfx, i), log_addr[i], exp_a[i]);
            check($sformatf("%s_wr%0d_data", pfx, i), log_data[i], exp_d[i]);
        end
        accept_result();
        check({pfx, "_idle_after"}, {30'd0, busy, res_valid}, 32'd0);
    endtask

    initial begin
        int guard;
        int n_log;
        rst_n = 1'b0; start = 1'b0; start_t = 1'b0; cfg_shift = '0;
        smp_valid = 1'b0; smp_value = '0; smp_last = 1'b0; res_ready = 1'b0;
        csr_req_ready = 1'b1; status_val = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_req", {29'd0, csr_req_valid, csr_wr_en, smp_ready}, 32'd0);
        check("rst_addr", csr_addr, 32'd0);
        check("rst_data", csr_wr_data, 32'd0);
        check("rst_res", {24'd0, res_valid, res_timeout, busy, res_class}, 32'd0);
        check("rst_rsp_ready", 32'(csr_rsp_ready), 32'd1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Case 1: nominal three-sample run
        run_case1("c1");

        // Cases 2/3: in_ready withheld for 10 polls, then a 5-cycle stall in WR_IN
        clear_logs();
        status_val = 32'h00;
        cfg_shift  = 6'd42;
        pulse_start(1'b0);
        send_sample(6'd9, 1'b1, 1'b0);
        guard = 0;
        while (rd_count < 10 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("c3_reads", 32'(rd_count), 32'd10);
        check("c3_no_input_wr", 32'(wr1_count), 32'd0);
        check("c3_still_polling", {29'd0, csr_req_valid, csr_wr_en, csr_addr == 32'd2},
              32'b101);
        status_val = 32'h02;
        @(negedge clk);
        csr_req_ready = 1'b0;
        n_log = log_data.size();
        check("c2_wr_in_req", {29'd0, csr_req_valid, csr_wr_en, csr_addr == 32'd1}, 32'b111);
        check("c2_wr_in_data", csr_wr_data, 32'h1513);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("c2_hold%0d_req", i),
                  {29'd0, csr_req_valid, csr_wr_en, csr_addr == 32'd1}, 32'b111);
            check($sformatf("c2_hold%0d_data", i), csr_wr_data, 32'h1513);
        end
        check("c2_no_advance", 32'(log_data.size()), 32'(n_log));
        csr_req_ready = 1'b1;
        status_val    = 32'hFC;
        wait_result(1'b0);
        check("c2_class", 32'(res_class), 32'd31);
        check("c2_wr_count", 32'(log_data.size()), 32'd5);
        if (log_data.size() == 5) begin
            check("c2_wr1", log_data[1], 32'h1513);
            check("c2_wr2", log_data[2], 32'h1500);
            check("c2_wr3", log_data[3], 32'h3500);
            check("c2_wr4", log_data[4], 32'h0);
        end
        accept_result();

        // Case 4: 8-poll timeout instance, out_valid never set
        clear_logs();
        status_val = 32'h02;
        cfg_shift  = 6'd1;
        pulse_start(1'b1);
        send_sample(6'd2, 1'b1, 1'b1);
        wait_result(1'b1);
        check("c4_timeout", 32'(res_timeout_t), 32'd1);
        check("c4_class", 32'(res_class_t), 32'd0);
        check("c4_poll_reads", 32'(post_done_reads), 32'd8);
        check("c4_wr_count", 32'(log_data_t.size()), 32'd5);
        if (log_data_t.size() == 5) begin
            check("c4_wr1", log_data_t[1], 32'h85);
            check("c4_wr3", log_data_t[3], 32'h2080);
            check("c4_wr4_addr", log_addr_t[4], 32'd1);
            check("c4_wr4_data", log_data_t[4], 32'h0);
        end
        accept_result();
        check("c4_idle", 32'(busy_t), 32'd0);

        // Case 5: reset asserted while a WR_IN write is stalled
        clear_logs();
        status_val = 32'h00;
        cfg_shift  = 6'd3;
        pulse_start(1'b0);
        send_sample(6'd5, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        status_val = 32'h02;
        @(negedge clk);
        csr_req_ready = 1'b0;
        check("c5_in_wr_in", {29'd0, csr_req_valid, csr_wr_en, csr_addr == 32'd1}, 32'b111);
        check("c5_wr_in_data", csr_wr_data, 32'h18B);
        #2 rst_n = 1'b0;
        #1;
        check("c5_rst_req", {29'd0, csr_req_valid, csr_wr_en, smp_ready}, 32'd0);
        check("c5_rst_addr", csr_addr, 32'd0);
        check("c5_rst_data", csr_wr_data, 32'd0);
        check("c5_rst_res", {24'd0, res_valid, res_timeout, busy, res_class}, 32'd0);
        check("c5_rst_rsp_ready", 32'(csr_rsp_ready), 32'd1);
        n_log = log_data.size();
        csr_req_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("c5_no_wr_in_reset", 32'(log_data.size()), 32'(n_log));
        rst_n = 1'b1;
        @(negedge clk);
        run_case1("c5");

        // Case 6: result held under res_ready low, start ignored around accept
        clear_logs();
        status_val = 32'h3E;
        cfg_shift  = 6'd0;
        pulse_start(1'b0);
        send_sample(6'd0, 1'b1, 1'b0);
        wait_result(1'b0);
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("c6_hold%0d", i), {25'd0, res_valid, busy, res_class},
                  {25'd0, 1'b1, 1'b1, 5'd7});
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        start     = 1'b0;
        check("c6_idle", {30'd0, busy, res_valid}, 32'd0);
        repeat (3) @(negedge clk);
        check("c6_start_ignored", {30'd0, busy, csr_req_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
